// File: rtl/cpu8_pkg.sv
// rtl/cpu8_pkg.sv - shared opcode, width and fetch-state definitions for the cpu8 core
package cpu8_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 8;

    localparam logic [2:0] OP_LI   = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_SLTI = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_J    = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-issue byte fetch unit with decoder handshake and branch redirect
// Optional: FETCH_JUMP_EARLY_EN resolves j instructions at fetch time.
module instr_fetch
    import cpu8_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               dec_ready,
    output logic               li_phase,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] flush_addr;
    logic            active;
    logic            ack_fire;

    // active keeps imem_req low for the first cycle out of reset
    assign imem_req  = active && (state != HOLD);
    assign imem_addr = (state == FLUSH) ? flush_addr : pc;
    assign ack_fire  = imem_req && imem_ack;

    always_comb begin
        pc_next = pc;
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (state == FETCH && ack_fire) begin
`ifdef FETCH_JUMP_EARLY_EN
            pc_next = (imem_rdata[7:5] == OP_J) ? {pc[PC_W-1:5], imem_rdata[4:0]}
                                                : pc + 8'd1;
`else
            pc_next = pc + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= 8'h00;
            flush_addr  <= 8'h00;
            active      <= 1'b0;
            instr       <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
            li_phase    <= 1'b0;
        end else begin
            active <= 1'b1;
            pc     <= pc_next;
            if (redirect_valid) begin
                instr_valid <= 1'b0;
                li_phase    <= 1'b0;
                case (state)
                    // an unanswered request must be drained at its original address
                    FETCH: begin
                        if (imem_req && !imem_ack) begin
                            state      <= FLUSH;
                            flush_addr <= pc;
                        end else begin
                            state <= FETCH;
                        end
                    end
                    HOLD:    state <= FETCH;
                    default: state <= FLUSH;
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (ack_fire) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (dec_ready) begin
                            instr_valid <= 1'b0;
                            if (instr[7:5] == OP_LI) begin
                                li_phase <= ~li_phase;
                            end
                            state <= FETCH;
                        end
                    end
                    FLUSH: begin
                        if (ack_fire) begin
                            state <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; held until imem_ack.
- imem_addr  output  8  fetch address; stable while imem_req=1.
- imem_ack  input  1  instruction memory response valid.
- imem_rdata  input  8  instruction byte; valid with imem_ack.
- instr  output  8  instruction to the control decoder.
- instr_valid  output  1  instr holds a live instruction.
- instr_pc  output  8  address of instr.
- dec_ready  input  1  decoder consumes instr this cycle when instr_valid=1.
- li_phase  output  1  0: the next li is its upper half (lui); 1: it is its lower half (lli).
- redirect_valid  input  1  taken beq from execute.
- redirect_pc  input  8  branch target.

Function
REQ-002 The block SHALL implement states FETCH, HOLD and FLUSH, encoded as a package enum.
REQ-003 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
- On imem_ack: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1, next state HOLD.
REQ-004 pc increment SHALL be modulo 256, so 8'hFF wraps to 8'h00.
REQ-005 In HOLD, imem_req SHALL be 0 and instr, instr_pc and instr_valid SHALL hold until dec_ready=1.
- On dec_ready=1: instr_valid<=0, next state FETCH.
REQ-006 Latency SHALL be one cycle from imem_ack to instr_valid=1; peak throughput is one instruction per 2 cycles.
REQ-007 li_phase SHALL toggle on each handshake (instr_valid & dec_ready) where instr[7:5]=3'b000; all other handshakes leave it unchanged.
REQ-008 redirect_valid SHALL have priority over imem_ack and dec_ready.
- It always sets pc<=redirect_pc, instr_valid<=0 and li_phase<=0.
- A handshake in the same cycle does not toggle li_phase.
REQ-009 Redirect in FETCH without imem_ack SHALL go to FLUSH.
- FLUSH keeps imem_req=1 and the old imem_addr until imem_ack.
- The response in FLUSH is discarded and the next state is FETCH.
REQ-010 Redirect in FETCH with imem_ack, or in HOLD, SHALL discard any data and go to FETCH.
REQ-011 Redirect in FLUSH SHALL update pc and remain in FLUSH.
REQ-012 imem_addr SHALL never change while imem_req=1 and imem_ack=0.

Reset
REQ-013 While rst_n=0, the block SHALL hold: pc=8'h00, state FETCH, instr=8'h00, instr_pc=8'h00, instr_valid=0, li_phase=0, imem_req=0.
REQ-014 imem_req SHALL rise on the first clock after rst_n deasserts, with imem_addr=8'h00.
REQ-015 Reset mid-request SHALL abandon the outstanding fetch; the memory must tolerate a dropped request.

Configuration
REQ-016 FETCH_JUMP_EARLY_EN SHALL select the jump handling.
- Defined: on imem_ack with imem_rdata[7:5]=3'b111 (and no redirect), pc<={pc[7:5], imem_rdata[4:0]} instead of pc+1; the j is still delivered to the decoder.
- Undefined: j is treated as an ordinary instruction (pc<=pc+1), and execute resolves it through redirect_valid.

Structure
REQ-017 Package cpu8_pkg SHALL hold:
- opcode constants OP_LI=3'b000, OP_LW=3'b001, OP_SW=3'b010, OP_ADDI=3'b011, OP_BEQ=3'b100, OP_SLTI=3'b101, OP_ADD=3'b110, OP_J=3'b111;
- PC_W=8 and INSTR_W=8;
- the fetch state enum.
REQ-018 The block SHALL be a single flat module with no sub-module; next-pc selection is one always block.

Verification
REQ-019 Scenario: reset, memory acks every request in the same cycle with bytes 0x61,0x22,0xC5 and dec_ready=1 -> instr 0x61/0x22/0xC5 at instr_pc 0x00/0x01/0x02, each 2 cycles apart.
REQ-020 Scenario: two consecutive li bytes 0x05 then 0x1A handshaken -> li_phase 0 before the first, 1 before the second, 0 after.
REQ-021 Scenario: dec_ready=0 for 5 cycles with instr 0x45 valid -> instr, instr_pc and instr_valid stable, imem_req=0 throughout.
REQ-022 Scenario: redirect_valid with redirect_pc=0x40 while a request to 0x03 is pending (ack delayed 3 cycles) -> imem_addr stays 0x03 until ack, that data is dropped, next imem_addr=0x40, li_phase=0.
REQ-023 Scenario: pc=0xFF fetch acked -> next imem_addr=0x00.
REQ-024 Scenario: with FETCH_JUMP_EARLY_EN, 0xF3 fetched at 0xA7 -> next imem_addr=0xB3; without the macro -> next imem_addr=0xA8.
